// File: rtl/mul_rr_arbiter_pkg.sv
// Shared definitions for the round-robin multiplier arbiter.
//   state_t      : sequencing states of the arbiter (ARB, ISSUE, WAIT)
//   DEF_*        : default widths, requester count and WAIT watchdog limit
//   clog2()      : ceiling log2, used to size index and counter fields
package mul_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_W     = 16;
  localparam int DEF_B_W     = 16;
  localparam int DEF_P_W     = DEF_A_W + DEF_B_W;
  localparam int DEF_TIMEOUT = 15;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_rr_arbiter_rr_pick.sv
// Round-robin winner selection (purely combinational).
//   eligible : one bit per requester that may be granted now
//   rr_ptr   : index with highest priority this round
//   found    : at least one requester is eligible
//   index    : first eligible index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ
module mul_rr_arbiter_rr_pick
  import mul_rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  // NOTE: every output gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    int j;
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && eligible[j]) begin
        found = 1'b1;
        index = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mul_rr_arbiter.sv
// Shares one 1-cycle-latency stream multiplier between NUM_REQ requesters.
// One multiply at a time: ARB picks a winner round-robin and latches its
// operands, ISSUE presents them until the multiplier accepts, WAIT routes the
// product into the winner's one-entry response buffer.
//   clk, reset           : clock, synchronous active-low reset
//   req_valid/ready/a/b  : per-requester operand handshake (packed operands)
//   rsp_valid/ready      : per-requester result handshake
//   rsp_payload          : packed per-requester result buffers
//   m_valid/ready        : handshake towards the multiplier input
//   m_payload_a/b        : operands towards the multiplier
//   m_result(_valid)     : multiplier output (no backpressure)
//   busy                 : a multiply is being sequenced (state != ARB)
//   grant_id             : index of the current/last grant
//   err_timeout          : sticky, WAIT watchdog expired without a result
//   err_spurious         : sticky, multiplier result arrived outside WAIT
module mul_rr_arbiter
  import mul_rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int A_W     = DEF_A_W,
  parameter  int B_W     = DEF_B_W,
  parameter  int P_W     = A_W + B_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [NUM_REQ*P_W-1:0] rsp_payload,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [A_W-1:0]         m_payload_a,
  output logic [B_W-1:0]         m_payload_b,
  input  logic [P_W-1:0]         m_result,
  input  logic                   m_result_valid,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   err_timeout,
  output logic                   err_spurious
);

  localparam int WD_W = clog2(TIMEOUT + 1);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [WD_W-1:0]  watchdog;
  logic [NUM_REQ-1:0] eligible;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             result_fire;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

  // A requester whose buffer still holds a result is skipped, so a fill and
  // a pop can never target the same buffer in the same cycle.
  assign eligible    = req_valid & ~rsp_valid;
  assign result_fire = (state == WAIT) && m_result_valid;
  assign busy        = (state != ARB);

  mul_rr_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .found    (pick_found),
    .index    (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    if (state == ARB && pick_found) req_ready[pick_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ARB;
      rr_ptr       <= '0;
      grant_id     <= '0;
      watchdog     <= '0;
      m_valid      <= 1'b0;
      m_payload_a  <= '0;
      m_payload_b  <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      // Results outside WAIT belong to no grant and are dropped.
      if (m_result_valid && state != WAIT) err_spurious <= 1'b1;

      case (state)
        ARB: begin
          if (pick_found) begin
            m_payload_a <= req_a[int'(pick_idx)*A_W +: A_W];
            m_payload_b <= req_b[int'(pick_idx)*B_W +: B_W];
            grant_id    <= pick_idx;
            m_valid     <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_valid  <= 1'b0;
            watchdog <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          watchdog <= watchdog + WD_W'(1);
          if (m_result_valid) begin
            rr_ptr <= next_idx(grant_id);
            state  <= ARB;
          end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
            // TIMEOUT WAIT cycles elapsed: abandon this grant, no response.
            err_timeout <= 1'b1;
            rr_ptr      <= next_idx(grant_id);
            state       <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    logic           buf_valid;
    logic [P_W-1:0] buf_payload;

    // NOTE: the payload storage is reset as well, so the packed result bus
    // reads zero after reset instead of stale or X data.
    always_ff @(posedge clk) begin
      if (!reset) begin
        buf_valid   <= 1'b0;
        buf_payload <= '0;
      end else if (result_fire && grant_id == IDX_W'(i)) begin
        buf_valid   <= 1'b1;
        buf_payload <= m_result;
      end else if (buf_valid && rsp_ready[i]) begin
        buf_valid <= 1'b0;
      end
    end

    assign rsp_valid[i]             = buf_valid;
    assign rsp_payload[i*P_W +: P_W] = buf_payload;
  end

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Scoreboard bench for mul_rr_arbiter: directed stimulus pushes expected
// grants and hand-computed products into queues; a monitor pops and compares
// whenever the DUT grants, issues to the multiplier or delivers a result.
module tb_mul_rr_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 15;

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
  } grant_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*16-1:0] req_a = '0;
  logic [N*16-1:0] req_b = '0;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready = '1;
  logic [N*32-1:0] rsp_payload;
  logic          m_valid;
  logic          m_ready;
  logic [15:0]   m_payload_a;
  logic [15:0]   m_payload_b;
  logic [31:0]   m_result;
  logic          m_result_valid;
  logic          busy;
  logic [1:0]    grant_id;
  logic          err_timeout;
  logic          err_spurious;

  // Multiplier model: one-cycle latency, not ready the cycle after an accept.
  logic        mul_busy = 1'b0;
  logic        mul_ovalid = 1'b0;
  logic [31:0] mul_res = '0;
  logic        stall = 1'b0;
  logic        drop = 1'b0;
  logic        spur = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  grant_t      exp_grant[$];
  grant_t      pend_issue[$];
  logic [31:0] exp_rsp[N][$];

  always #5 clk = ~clk;

  assign m_ready        = !mul_busy && !stall;
  assign m_result       = mul_res;
  assign m_result_valid = mul_ovalid | spur;

  always @(posedge clk) begin
    mul_busy   <= m_valid && m_ready;
    mul_ovalid <= m_valid && m_ready && !drop;
    if (m_valid && m_ready) mul_res <= 32'(m_payload_a) * 32'(m_payload_b);
  end

  mul_rr_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_payload    (rsp_payload),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_payload_a    (m_payload_a),
    .m_payload_b    (m_payload_b),
    .m_result       (m_result),
    .m_result_valid (m_result_valid),
    .busy           (busy),
    .grant_id       (grant_id),
    .err_timeout    (err_timeout),
    .err_spurious   (err_spurious)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, once inputs settled.
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      if (req_ready != '0) begin
        if (exp_grant.size() == 0) begin
          check("grant_unexpected", 64'(req_ready), 64'd0);
        end else begin
          grant_t g;
          g = exp_grant.pop_front();
          check($sformatf("grant_order_%0d", g.idx), 64'(req_ready), 64'd1 << g.idx);
          pend_issue.push_back(g);
        end
      end
      if (m_valid && m_ready) begin
        if (pend_issue.size() == 0) begin
          check("issue_unexpected", 64'(m_valid), 64'd0);
        end else begin
          grant_t g;
          g = pend_issue.pop_front();
          check($sformatf("issue_a_%0d", g.idx), 64'(m_payload_a), 64'(g.a));
          check($sformatf("issue_b_%0d", g.idx), 64'(m_payload_b), 64'(g.b));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (exp_rsp[i].size() == 0)
            check($sformatf("rsp_unexpected_%0d", i), 64'(rsp_payload[i*32 +: 32]), 64'hDEAD);
          else
            check($sformatf("rsp_payload_%0d", i), 64'(rsp_payload[i*32 +: 32]),
                  64'(exp_rsp[i].pop_front()));
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input int idx, input logic [15:0] a, input logic [15:0] b);
    bit got;
    got = 1'b0;
    req_a[idx*16 +: 16] = a;
    req_b[idx*16 +: 16] = b;
    req_valid[idx]      = 1'b1;
    for (int c = 0; c < 400 && !got; c++) begin
      #1;
      if (req_ready[idx]) begin
        got = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    req_valid[idx] = 1'b0;
    check($sformatf("send_accept_%0d", idx), 64'(got), 64'd1);
  endtask

  task automatic wait_rsp(input int idx);
    for (int c = 0; c < 20 && !rsp_valid[idx]; c++) @(negedge clk);
    #1;
    check($sformatf("rsp_arrive_%0d", idx), 64'(rsp_valid[idx]), 64'd1);
  endtask

  task automatic push_grant(input int idx, input logic [15:0] a, input logic [15:0] b);
    grant_t g;
    g.idx = idx;
    g.a   = a;
    g.b   = b;
    exp_grant.push_back(g);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit early;
    bit saw1;
    bit done1;
    bit done2;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_payload", 64'(rsp_payload[63:0] | rsp_payload[127:64]), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_payload", 64'({m_payload_a, m_payload_b}), 64'd0);
    check("rst_busy_grant", 64'({busy, grant_id}), 64'd0);
    check("rst_errs", 64'({err_timeout, err_spurious}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // ---------------- single request + latency ----------------
    push_grant(0, 16'd3, 16'd7);  exp_rsp[0].push_back(32'd21);
    push_grant(1, 16'd4, 16'd5);  exp_rsp[1].push_back(32'd20);
    req_a[15:0] = 16'd3;
    req_b[15:0] = 16'd7;
    req_valid[0] = 1'b1;
    #1;
    check("single_ready_T", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_a[31:16] = 16'd4;
    req_b[31:16] = 16'd5;
    req_valid[1] = 1'b1;
    #1;
    check("single_mvalid_T1", 64'(m_valid), 64'd1);
    check("single_ops_T1", 64'({m_payload_a, m_payload_b}), 64'h0003_0007);
    check("single_nogrant_T1", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    check("single_wait_T2", 64'({m_valid, busy, rsp_valid}), 64'b1_0000 << 0 | 64'h10);
    check("single_nogrant_T2", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    check("single_rsp_valid_T3", 64'(rsp_valid), 64'b0001);
    check("single_rsp_payload_T3", 64'(rsp_payload[31:0]), 64'd21);
    check("single_regrant_T3", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);

    // ---------------- round-robin, all valid ----------------
    // rr_ptr is 2 after the grant to requester 1 completed.
    push_grant(2, 16'd100, 16'd200);
    push_grant(3, 16'h1234, 16'h0010);
    push_grant(0, 16'hFFFF, 16'hFFFF);
    push_grant(1, 16'd2, 16'd3);
    push_grant(2, 16'd7, 16'd9);
    push_grant(3, 16'hFFFF, 16'h0001);
    push_grant(0, 16'h0000, 16'h5555);
    push_grant(1, 16'h8000, 16'h0002);
    exp_rsp[0].push_back(32'hFFFE_0001); exp_rsp[0].push_back(32'h0000_0000);
    exp_rsp[1].push_back(32'h0000_0006); exp_rsp[1].push_back(32'h0001_0000);
    exp_rsp[2].push_back(32'h0000_4E20); exp_rsp[2].push_back(32'h0000_003F);
    exp_rsp[3].push_back(32'h0001_2340); exp_rsp[3].push_back(32'h0000_FFFF);
    fork
      begin send(0, 16'hFFFF, 16'hFFFF); send(0, 16'h0000, 16'h5555); end
      begin send(1, 16'd2, 16'd3);       send(1, 16'h8000, 16'h0002); end
      begin send(2, 16'd100, 16'd200);   send(2, 16'd7, 16'd9);       end
      begin send(3, 16'h1234, 16'h0010); send(3, 16'hFFFF, 16'h0001); end
    join
    repeat (4) @(negedge clk);

    // ---------------- response backpressure ----------------
    rsp_ready[1] = 1'b0;
    push_grant(1, 16'd5, 16'd6);    exp_rsp[1].push_back(32'd30);
    send(1, 16'd5, 16'd6);
    wait_rsp(1);
    push_grant(3, 16'd11, 16'd12);  exp_rsp[3].push_back(32'd132);
    push_grant(1, 16'd9, 16'd9);    exp_rsp[1].push_back(32'd81);
    @(negedge clk);
    done1 = 1'b0;
    fork
      begin send(1, 16'd9, 16'd9); done1 = 1'b1; end
    join_none
    send(3, 16'd11, 16'd12);
    saw1 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      saw1 |= req_ready[1];
      @(negedge clk);
    end
    #1;
    check("bp_no_regrant", 64'(saw1), 64'd0);
    check("bp_held_valid", 64'(rsp_valid[1]), 64'd1);
    check("bp_held_payload", 64'(rsp_payload[63:32]), 64'd30);
    @(negedge clk);
    rsp_ready[1] = 1'b1;
    for (int c = 0; c < 40 && !done1; c++) @(negedge clk);
    check("bp_regrant_after_pop", 64'(done1), 64'd1);
    repeat (4) @(negedge clk);

    // ---------------- multiplier stall ----------------
    // rr_ptr is 2; requester 0 is the only one valid.
    push_grant(0, 16'h1111, 16'h0002);  exp_rsp[0].push_back(32'h2222);
    push_grant(2, 16'd3, 16'd3);        exp_rsp[2].push_back(32'd9);
    stall = 1'b1;
    send(0, 16'h1111, 16'h0002);
    done2 = 1'b0;
    fork
      begin send(2, 16'd3, 16'd3); done2 = 1'b1; end
    join_none
    early = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (!m_valid || m_payload_a != 16'h1111 || m_payload_b != 16'h0002 || req_ready != '0)
        early = 1'b1;
      @(negedge clk);
    end
    check("stall_hold_stable", 64'(early), 64'd0);
    stall = 1'b0;
    @(negedge clk);
    #1;
    check("stall_transfer_first_ready", 64'({m_valid, busy}), 64'b01);
    for (int c = 0; c < 40 && !done2; c++) @(negedge clk);
    check("stall_next_served", 64'(done2), 64'd1);
    repeat (4) @(negedge clk);

    // ---------------- timeout ----------------
    // rr_ptr is 3; the multiplier model swallows the result.
    drop = 1'b1;
    push_grant(3, 16'd4, 16'd4);
    send(3, 16'd4, 16'd4);
    @(posedge clk);
    early = 1'b0;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      #1;
      early |= err_timeout | ~busy;
    end
    check("timeout_not_early", 64'(early), 64'd0);
    @(negedge clk);
    #1;
    check("timeout_set", 64'(err_timeout), 64'd1);
    check("timeout_back_to_arb", 64'(busy), 64'd0);
    check("timeout_no_rsp", 64'(rsp_valid), 64'd0);
    check("timeout_grant_id", 64'(grant_id), 64'd3);
    drop = 1'b0;
    // Resumes at rr_ptr = 0: requester 0 wins over 3.
    push_grant(0, 16'd6, 16'd7);  exp_rsp[0].push_back(32'd42);
    push_grant(3, 16'd8, 16'd8);  exp_rsp[3].push_back(32'd64);
    @(negedge clk);
    fork
      send(0, 16'd6, 16'd7);
      send(3, 16'd8, 16'd8);
    join
    repeat (4) @(negedge clk);

    // ---------------- spurious result in ARB ----------------
    #1;
    check("spur_clear_before", 64'(err_spurious), 64'd0);
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1;
    check("spur_set", 64'(err_spurious), 64'd1);
    check("spur_no_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk);

    // ---------------- reset mid-operation ----------------
    rsp_ready[2] = 1'b0;
    push_grant(2, 16'd10, 16'd10);
    send(2, 16'd10, 16'd10);
    wait_rsp(2);
    @(negedge clk);
    drop = 1'b1;
    push_grant(1, 16'd2, 16'd2);
    send(1, 16'd2, 16'd2);
    @(negedge clk);
    #1;
    check("mid_pre_busy_full", 64'({busy, rsp_valid}), 64'b1_0100);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    check("mid_rst_payload", 64'(rsp_payload[63:0] | rsp_payload[127:64]), 64'd0);
    check("mid_rst_mside", 64'({m_valid, m_payload_a, m_payload_b}), 64'd0);
    check("mid_rst_state", 64'({busy, grant_id, err_timeout, err_spurious}), 64'd0);
    reset = 1'b1;
    rsp_ready = '1;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    drop = 1'b0;
    #1;
    check("mid_late_spurious", 64'(err_spurious), 64'd1);
    check("mid_late_no_effect", 64'({rsp_valid, err_timeout, busy}), 64'd0);
    // rr_ptr restarted at 0: requester 0 wins over 3.
    push_grant(0, 16'd1, 16'd1);  exp_rsp[0].push_back(32'd1);
    push_grant(3, 16'd2, 16'd5);  exp_rsp[3].push_back(32'd10);
    @(negedge clk);
    fork
      send(0, 16'd1, 16'd1);
      send(3, 16'd2, 16'd5);
    join

    // ---------------- drain ----------------
    for (int c = 0; c < 50; c++) begin
      if (exp_grant.size() == 0 && pend_issue.size() == 0 &&
          exp_rsp[0].size() == 0 && exp_rsp[1].size() == 0 &&
          exp_rsp[2].size() == 0 && exp_rsp[3].size() == 0) break;
      @(negedge clk);
    end
    check("drain_grants", 64'(exp_grant.size() + pend_issue.size()), 64'd0);
    for (int i = 0; i < N; i++)
      check($sformatf("drain_rsp_%0d", i), 64'(exp_rsp[i].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
